sevenseg_scan: RTL

Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. Takes a packed hex/BCD value and per-digit decimal points, and scans one digit at a time. Each digit slot starts with an anti-ghosting blank gap. New values are applied only at frame boundaries, so a frame never mixes old and new digits. Sits between the application datapath and the board's segment, decimal-point and anode pins.

---
 rtl/sevenseg_pkg.sv | 52 +++++
 rtl/sevenseg_scan_decode.sv | 21 ++
 rtl/sevenseg_scan.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared segment patterns and nibble decode for the seven-segment scanner.
// Active-low patterns, bit order {a,b,c,d,e,f,g}.
package sevenseg_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0001100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Nibble to pattern; letters A..F only when hex_en, otherwise blank.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nib,
                                                  input logic       hex_en);
    logic [SEG_W-1:0] pat;
    pat = SEG_BLANK;
    case (nib)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = hex_en ? SEG_A : SEG_BLANK;
      4'hB: pat = hex_en ? SEG_B : SEG_BLANK;
      4'hC: pat = hex_en ? SEG_C : SEG_BLANK;
      4'hD: pat = hex_en ? SEG_D : SEG_BLANK;
      4'hE: pat = hex_en ? SEG_E : SEG_BLANK;
      4'hF: pat = hex_en ? SEG_F : SEG_BLANK;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sevenseg_scan_decode.sv
// Combinational nibble-to-segment decoder (module sevenseg_decode).
// Define SEVSEG_HEX_EN to show A..F; otherwise nibbles 10..15 are blank.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o_c
);

`ifdef SEVSEG_HEX_EN
  localparam logic HEX_EN = 1'b1;
`else
  localparam logic HEX_EN = 1'b0;
`endif

  // Pure table lookup.
  always_comb begin
    seg_o_c = seg_decode(nibble_i, HEX_EN);
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with per-slot blank gap
// and frame-aligned value updates. Hex letters need SEVSEG_HEX_EN (in decoder).
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned GAP      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     pend_val_q, pend_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic              pend_flag_q, pend_flag_d;
  logic [VW-1:0]     shd_val_q, shd_val_d;
  logic [DIGITS-1:0] shd_dp_q, shd_dp_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              fs_q, fs_d;

  logic              boundary_c;
  logic              gap_c;
  logic [3:0]        nib_c;
  logic [SEG_W-1:0]  seg_dec_c;

  // Counters, pending capture and frame-aligned shadow update.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    shd_val_d   = shd_val_q;
    shd_dp_d    = shd_dp_q;
    boundary_c  = 1'b0;

    if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d      = '0;
        idx_d      = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        boundary_c = (idx_q == IDX_MAX);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end

    // A load landing on the boundary goes straight to the shadow copy.
    if (boundary_c) begin
      if (load) begin
        shd_val_d   = value;
        shd_dp_d    = dp_in;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        shd_val_d   = pend_val_q;
        shd_dp_d    = pend_dp_q;
        pend_flag_d = 1'b0;
      end
    end
  end

  // Gap detection on the next counter value; no gap logic when GAP is zero.
  if (GAP == 0) begin : g_nogap
    assign gap_c = 1'b0;
  end else begin : g_gap
    assign gap_c = (cnt_d < CW'(GAP));
  end

  assign nib_c = shd_val_d[4*idx_d +: 4];

  sevenseg_decode u_decode (
    .nibble_i (nib_c),
    .seg_o_c  (seg_dec_c)
  );

  // Output selection from next-state so the output flops carry no extra lag.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    fs_d  = 1'b0;
    if (en) begin
      fs_d = (cnt_d == '0) && (idx_d == '0);
      if (!gap_c) begin
        an_d  = ~(DIGITS'(1) << idx_d);
        seg_d = seg_dec_c;
        dp_d  = ~shd_dp_d[idx_d];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      shd_val_q   <= '0;
      shd_dp_q    <= '0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      an_q        <= '1;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      shd_val_q   <= shd_val_d;
      shd_dp_q    <= shd_dp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      fs_q        <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule
